// File: rtl/ddr3_ui_emu_pkg.sv
// Shared types and default timing for the DDR3 user-interface emulator.
package ddr3_ui_emu_pkg;
    localparam int WORD_W          = 16;
    localparam int BURST           = 8;
    localparam int CNT_W           = 16;
    localparam int DEF_INIT_CYCLES = 64;
    localparam int DEF_WR_LAT      = 8;
    localparam int DEF_RD_LAT      = 12;
    localparam int DEF_REF_LAT     = 20;
    localparam int DEF_REF_MAX     = 1562;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_REFRESH
    } state_t;
endpackage

// File: rtl/ddr3_ui_emu_ram.sv
// Single-port synchronous RAM, 1-cycle read latency, no reset so it maps to block RAM.
module ddr3_ui_emu_ram #(
    parameter int AW = 12,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/ddr3_ui_emu.sv
// DDR3 controller user-interface responder backed by on-chip RAM.
// Optional refresh-gap checker: define DDR3_UI_EMU_REFCHK_EN.
module ddr3_ui_emu
    import ddr3_ui_emu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 26,
    parameter int MEM_AW      = 12,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int WR_LAT      = DEF_WR_LAT,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int REF_LAT     = DEF_REF_LAT,
    parameter int REF_MAX     = DEF_REF_MAX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic                         rd,
    input  logic                         wr,
    input  logic                         refresh,
    input  logic [WORD_W-1:0]            din,
    output logic [WORD_W-1:0]            dout,
    output logic [BURST*WORD_W-1:0]      dout128,
    output logic                         data_ready,
    output logic                         busy,
    output logic                         calib_done,
    output logic                         proto_err,
    output logic                         ref_late
);
    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic [MEM_AW-1:0]               cmd_addr;
    logic [WORD_W-1:0]               wdata;
    logic [BURST-1:0][WORD_W-1:0]    stage;
    logic                            ram_we;
    logic [MEM_AW-1:0]               ram_addr;
    logic [WORD_W-1:0]               ram_q;
    logic                            any_strb, multi_strb, accept;
    logic                            addr_hi_unused;

    assign addr_hi_unused = ^addr[ADDR_WIDTH-1:MEM_AW];
    assign any_strb   = rd | wr | refresh;
    assign multi_strb = (rd & wr) | (rd & refresh) | (wr & refresh);
    assign accept     = any_strb & ~multi_strb & (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        unique case (state)
            ST_INIT:    if (cnt == CNT_W'(INIT_CYCLES - 1)) begin state_nxt = ST_IDLE; cnt_nxt = '0; end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = wr ? ST_WRITE : (rd ? ST_READ : ST_REFRESH);
            end
            ST_WRITE:   if (cnt == CNT_W'(WR_LAT - 1))  begin state_nxt = ST_IDLE; cnt_nxt = '0; end
            ST_READ:    if (cnt == CNT_W'(RD_LAT - 1))  begin state_nxt = ST_IDLE; cnt_nxt = '0; end
            ST_REFRESH: if (cnt == CNT_W'(REF_LAT - 1)) begin state_nxt = ST_IDLE; cnt_nxt = '0; end
            default:    begin state_nxt = ST_IDLE; cnt_nxt = '0; end
        endcase
    end

    // Word 0 of the burst is read on the accept edge, so words 1..7 follow in READ.
    always_comb begin
        busy       = (state != ST_IDLE);
        calib_done = (state != ST_INIT);
        data_ready = (state == ST_READ) && (cnt == CNT_W'(RD_LAT - 1));
        ram_we     = (state == ST_WRITE) && (cnt == '0);
        ram_addr   = cmd_addr;
        unique case (state)
            ST_IDLE: ram_addr = {addr[MEM_AW-1:3], 3'd0};
            ST_READ: ram_addr = {cmd_addr[MEM_AW-1:3], cnt[2:0] + 3'd1};
            default: ram_addr = cmd_addr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_addr  <= '0;
            wdata     <= '0;
            stage     <= '0;
            dout      <= '0;
            dout128   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                cmd_addr <= addr[MEM_AW-1:0];
                wdata    <= din;
            end
            if (any_strb && (multi_strb || busy)) proto_err <= 1'b1;
            if (state == ST_READ && cnt < CNT_W'(BURST)) stage[cnt[2:0]] <= ram_q;
            // Outputs load one edge early so they are valid in the data_ready cycle.
            if (state == ST_READ && cnt == CNT_W'(RD_LAT - 2)) begin
                dout    <= stage[cmd_addr[2:0]];
                dout128 <= stage;
            end
        end
    end

    ddr3_ui_emu_ram #(.AW(MEM_AW), .W(WORD_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_q)
    );

`ifdef DDR3_UI_EMU_REFCHK_EN
    logic [CNT_W-1:0] ref_cnt;
    logic             ref_late_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt    <= '0;
            ref_late_q <= 1'b0;
        end else begin
            if (state == ST_INIT || (accept && refresh)) ref_cnt <= '0;
            else if (ref_cnt != '1)                      ref_cnt <= ref_cnt + 1'b1;
            if (ref_cnt > CNT_W'(REF_MAX)) ref_late_q <= 1'b1;
        end
    end
    assign ref_late = ref_late_q;
`else
    assign ref_late = 1'b0;
`endif
endmodule

// File: doc/ddr3_ui_emu.md
# ddr3_ui_emu

Behavioural responder for the DDR3 controller user interface (addr/rd/wr/refresh/din/dout/dout128/data_ready/busy). It is a drop-in substitute for the DDR3 controller: test and bring-up logic runs against an on-chip 16-bit RAM instead of external DDR3. Latencies and the busy/data_ready handshake match the controller contract. Protocol violations by the initiator are flagged with sticky error bits.

## Interface
- ADDR_WIDTH, 26, width of the word address from the initiator
- MEM_AW, 12, backing RAM address bits (2^MEM_AW 16-bit words); upper address bits are ignored, so accesses alias modulo 2^MEM_AW
- INIT_CYCLES, 64, cycles busy stays high after reset release
- WR_LAT, 8, busy duration of a write; must be at least 2
- RD_LAT, 12, cycles from rd acceptance to data_ready; must be at least 10
- REF_LAT, 20, busy duration of a refresh; must be at least 2
- REF_MAX, 1562, maximum cycles allowed between refreshes (used only with DDR3_UI_EMU_REFCHK_EN)
- clk  in  1  pclk-domain clock
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_WIDTH  word address, sampled with rd/wr
- rd  in  1  read strobe, one cycle
- wr  in  1  write strobe, one cycle
- refresh  in  1  refresh strobe, one cycle
- din  in  16  write data, sampled with wr
- dout  out  16  word at the read address
- dout128  out  128  the 8-word burst containing the read address; word k sits in bits [16k+15:16k]
- data_ready  out  1  one-cycle pulse when dout and dout128 are valid
- busy  out  1  high means the block cannot accept a command
- calib_done  out  1  high once the init phase is complete
- proto_err  out  1  sticky: a strobe arrived while busy, or more than one strobe arrived in the same cycle
- ref_late  out  1  sticky: refresh gap exceeded REF_MAX (held at 0 without the macro)

## Operation
- Reset values: busy=1, data_ready=0, dout=0, dout128=0, calib_done=0, proto_err=0, ref_late=0. RAM contents are not reset.
- States: INIT, IDLE, WRITE, READ, REFRESH.
- INIT: count INIT_CYCLES after reset release, then set calib_done=1, drop busy, go to IDLE.
- IDLE: accept exactly one strobe per cycle, and only while busy=0.
  - wr: go to WRITE.
  - rd: go to READ.
  - refresh: go to REFRESH.
- Strobe while busy, or two or more strobes in the same cycle: the command is ignored, proto_err is set, and the state does not change.
- Any strobe during INIT also sets proto_err.
- WRITE: the RAM is written at the first cycle after acceptance, at address addr[MEM_AW-1:0] with data din.
- READ: fetch the 8 words at {addr[MEM_AW-1:3], 3'd0}..+7 in sequence, one RAM read per cycle, into the dout128 staging register. Also capture the word at addr[2:0] for dout.
  - dout and dout128 update only in the data_ready cycle and hold until the next read completes.
- REFRESH: no RAM access. Resets the refresh-gap counter.
- Address aliasing: addr bits above MEM_AW are dropped. Example: address 2^MEM_AW + 5 maps to word 5.
- Reset mid-operation returns to INIT with the reset values above. A pending write may or may not have landed.

## Timing
- Command accepted at edge N (strobe=1, busy=0). busy=1 from cycle N+1. A registered busy guarantees busy is already high in the first cycle after the strobe.
- Write: busy is high for cycles N+1..N+WR_LAT, low from N+WR_LAT+1.
- Read: data_ready=1 only in cycle N+RD_LAT; busy is low from N+RD_LAT+1.
- Refresh: busy is high for cycles N+1..N+REF_LAT.
- Back-to-back: a new strobe is legal in the first cycle busy reads 0.
- RAM read latency is 1 cycle. The 8-word fetch completes by N+9, which is why RD_LAT must be at least 10.

## Configuration
- DDR3_UI_EMU_REFCHK_EN defined:
  - a refresh-gap counter runs from INIT exit;
  - ref_late is set when the counter exceeds REF_MAX;
  - the counter clears on each accepted refresh and saturates at its maximum.
- Not defined: no counter is built and ref_late is tied to 0.

## Structure
- Package ddr3_ui_emu_pkg:
  - state enum;
  - WORD_W=16, BURST=8;
  - default latency localparams.
- Sub-module ddr3_ui_emu_ram: single-port 2^MEM_AW x 16 synchronous RAM with 1-cycle read, inferable as BSRAM.
- Top level contains the FSM, latency counter, burst fetch counter, sticky flags and, when enabled, the refresh counter.

## Test plan
- Reset release, then wait INIT_CYCLES -> busy falls and calib_done=1 at cycle INIT_CYCLES; proto_err=0.
- Write 0x1122 to address 0, 0x3344 to 1 and 0x5566 to 2, then read address 1 -> dout=0x3344 and dout128[47:0]=0x5566_3344_1122. data_ready arrives exactly RD_LAT cycles after rd.
- Write 0xBEEF to address 2^MEM_AW+5, then read address 5 -> dout=0xBEEF (aliasing).
- wr asserted while busy, and separately rd+wr in the same cycle -> proto_err=1, and the RAM is unchanged (a read returns the prior value).
- With DDR3_UI_EMU_REFCHK_EN: issue no refresh for REF_MAX+1 cycles -> ref_late=1. Refreshing every 781 cycles keeps ref_late=0.
- Assert reset in the middle of a read -> busy=1 and data_ready never pulses. A fresh INIT follows, and a subsequent read returns data.
